knn_result_uart_tx: RTL and testbench

- Output-side counterpart to the switch/button input controller. On each classification result, it serializes a fixed 7-byte report frame over a UART TX line to a host PC.
- Frame contents: the query point, K mode, predicted class and latency count.
- Sits in the top level beside the voting and latency_counter blocks. Driven by the engine's done pulse; LEDs are unaffected.

---
 rtl/knn_result_uart_tx_pkg.sv | 40 ++++
 rtl/knn_result_uart_tx_byte.sv | 105 ++++++++++
 rtl/knn_result_uart_tx.sv | 150 +++++++++++++++
 tb/tb_knn_result_uart_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/knn_result_uart_tx_pkg.sv
// Shared types and constants for the KNN result report transmitter.
// Covers the frame layout, the flag-byte format and both FSM encodings.
package knn_result_uart_tx_pkg;

    localparam int FRAME_LEN = 7;
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    typedef logic [2:0] byte_idx_t;
    localparam byte_idx_t LAST_BYTE_IDX = byte_idx_t'(FRAME_LEN - 1);

    // Layout of B3: reserved zeros, then K mode, then the predicted class in bit 0
    typedef struct packed {
        logic [5:0] reserved;
        logic       k_mode;
        logic       predicted_class;
    } flag_byte_t;

    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_LOAD,
        FRM_SEND,
        FRM_DONE
    } frame_state_t;

    typedef enum logic [1:0] {
        BIT_IDLE,
        BIT_START,
        BIT_DATA,
        BIT_STOP
    } bit_state_t;

    function automatic logic [7:0] make_flag_byte(input logic k_mode, input logic predicted_class);
        flag_byte_t f;
        f.reserved        = '0;
        f.k_mode          = k_mode;
        f.predicted_class = predicted_class;
        return f;
    endfunction

endpackage

// File: rtl/knn_result_uart_tx_byte.sv
// 8N1 byte serializer holding all UART bit timing.
// A start request during the final stop-bit cycle chains the next byte with no idle gap.
module uart_tx_byte
    import knn_result_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       byte_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    bit_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic             last_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= BIT_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx_reg    <= tx_next;
        end
    end

    assign last_tick = (cnt_reg == CNT_LAST);

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        tx_next    = tx_reg;
        if (state_reg != BIT_IDLE && !last_tick) begin
            cnt_next = cnt_reg + 1'b1;
        end
        case (state_reg)
            BIT_IDLE: begin
                tx_next = 1'b1;
                if (start) begin
                    shift_next = data;
                    tx_next    = 1'b0;
                    state_next = BIT_START;
                end
            end
            BIT_START: begin
                if (last_tick) begin
                    tx_next    = shift_reg[0];
                    shift_next = {1'b0, shift_reg[7:1]};
                    bit_next   = '0;
                    state_next = BIT_DATA;
                end
            end
            BIT_DATA: begin
                if (last_tick) begin
                    if (bit_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = BIT_STOP;
                    end else begin
                        tx_next    = shift_reg[0];
                        shift_next = {1'b0, shift_reg[7:1]};
                        bit_next   = bit_reg + 1'b1;
                    end
                end
            end
            BIT_STOP: begin
                if (last_tick) begin
                    if (start) begin
                        shift_next = data;
                        tx_next    = 1'b0;
                        state_next = BIT_START;
                    end else begin
                        state_next = BIT_IDLE;
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = BIT_IDLE;
            end
        endcase
    end

    assign tx        = tx_reg;
    assign busy      = (state_reg != BIT_IDLE);
    assign byte_done = (state_reg == BIT_STOP) && last_tick;

endmodule

// File: rtl/knn_result_uart_tx.sv
// Sends a 7-byte report frame (header, query point, flags, latency, checksum) per classification.
// The header goes to the serializer straight from the accept cycle, so the start bit follows at once.
module knn_result_uart_tx
    import knn_result_uart_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter logic [7:0] HEADER_BYTE  = HEADER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        report,
    input  logic [7:0]  x_input,
    input  logic [7:0]  y_input,
    input  logic        predicted_class,
    input  logic        K_mode,
    input  logic [15:0] latency,
    output logic        tx,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  frame_count
);

    frame_state_t state_reg, state_next;
    byte_idx_t    idx_reg, idx_next, next_idx;
    logic         busy_reg, busy_next;
    logic         overrun_reg, overrun_next;
    logic [7:0]   count_reg, count_next;
    logic [7:0]   frame_reg [FRAME_LEN];
    logic [7:0]   frame_bytes [FRAME_LEN];
    logic [7:0]   checksum;
    logic [7:0]   tx_data;
    logic         accept;
    logic         byte_start;
    logic         byte_busy;
    logic         byte_done;

    assign frame_bytes[0] = HEADER_BYTE;
    assign frame_bytes[1] = x_input;
    assign frame_bytes[2] = y_input;
    assign frame_bytes[3] = make_flag_byte(K_mode, predicted_class);
    assign frame_bytes[4] = latency[15:8];
    assign frame_bytes[5] = latency[7:0];
    assign frame_bytes[6] = checksum;

    // Checksum covers payload only; the header is excluded
    always_comb begin
        checksum = '0;
        for (int i = 1; i < FRAME_LEN - 1; i++) begin
            checksum = checksum ^ frame_bytes[i];
        end
    end

    assign accept   = report && !busy_reg;
    assign next_idx = idx_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                frame_reg[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                frame_reg[i] <= frame_bytes[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FRM_IDLE;
            idx_reg     <= '0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            busy_reg    <= busy_next;
            overrun_reg <= overrun_next;
            count_reg   <= count_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        busy_next    = busy_reg;
        overrun_next = overrun_reg;
        count_next   = count_reg;
        byte_start   = 1'b0;
        if (report && busy_reg) begin
            overrun_next = 1'b1;
        end
        case (state_reg)
            FRM_IDLE, FRM_DONE: begin
                state_next = FRM_IDLE;
                if (accept) begin
                    state_next = FRM_LOAD;
                    idx_next   = '0;
                    busy_next  = 1'b1;
                    byte_start = 1'b1;
                end
            end
            FRM_LOAD: begin
                if (byte_busy) begin
                    state_next = FRM_SEND;
                end
            end
            FRM_SEND: begin
                if (byte_done) begin
                    if (idx_reg == LAST_BYTE_IDX) begin
                        state_next = FRM_DONE;
                        busy_next  = 1'b0;
                        count_next = count_reg + 1'b1;
                    end else begin
                        state_next = FRM_LOAD;
                        idx_next   = next_idx;
                        byte_start = 1'b1;
                    end
                end
            end
            default: state_next = FRM_IDLE;
        endcase
    end

    // Next byte is handed over in the stop-bit's last cycle so bytes abut
    always_comb begin
        tx_data = HEADER_BYTE;
        if (!accept && idx_reg != LAST_BYTE_IDX) begin
            tx_data = frame_reg[next_idx];
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk       (clk),
        .reset     (reset),
        .start     (byte_start),
        .data      (tx_data),
        .tx        (tx),
        .busy      (byte_busy),
        .byte_done (byte_done)
    );

    assign busy        = busy_reg;
    assign overrun     = overrun_reg;
    assign frame_count = count_reg;

endmodule

// File: tb/tb_knn_result_uart_tx.sv
// Self-checking bench for knn_result_uart_tx with CLKS_PER_BIT=4.
// Frames are predicted from field values and compared against the sampled tx waveform.
module tb_knn_result_uart_tx;

    localparam int CPB       = 4;
    localparam int BITS      = 70;
    localparam int FRAME_CYC = BITS * CPB;

    logic        clk;
    logic        reset;
    logic        report;
    logic [7:0]  x_input;
    logic [7:0]  y_input;
    logic        predicted_class;
    logic        K_mode;
    logic [15:0] latency;
    logic        tx;
    logic        busy;
    logic        overrun;
    logic [7:0]  frame_count;

    int          checks;
    int          errors;
    logic [7:0]  exp_count;
    logic        exp_ovr;
    logic [55:0] last_dec;
    logic [FRAME_CYC-1:0] obs;

    knn_result_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .report         (report),
        .x_input        (x_input),
        .y_input        (y_input),
        .predicted_class(predicted_class),
        .K_mode         (K_mode),
        .latency        (latency),
        .tx             (tx),
        .busy           (busy),
        .overrun        (overrun),
        .frame_count    (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Byte j of the frame sits in bits [8j +: 8]
    function automatic logic [55:0] model_frame(input logic [7:0] x, input logic [7:0] y,
                                                input logic c, input logic k, input logic [15:0] lat);
        logic [7:0] b [7];
        logic [55:0] f;
        b[0] = 8'hA5;
        b[1] = x;
        b[2] = y;
        b[3] = 8'((k ? 2 : 0) + (c ? 1 : 0));
        b[4] = 8'(lat / 256);
        b[5] = 8'(lat % 256);
        b[6] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5];
        f = '0;
        for (int j = 0; j < 7; j++) f[j*8 +: 8] = b[j];
        return f;
    endfunction

    // Expected line level for each of the 40 cycles of one byte: start, d0..d7, stop
    function automatic logic [39:0] byte_window(input logic [7:0] b);
        logic [9:0]  cells;
        logic [39:0] w;
        cells = {1'b1, b, 1'b0};
        for (int p = 0; p < 40; p++) w[p] = cells[p / CPB];
        return w;
    endfunction

    task automatic run_frame(input logic [7:0] x, input logic [7:0] y, input logic c,
                             input logic k, input logic [15:0] lat, input int ovr_at);
        logic [55:0] ef;
        logic [7:0]  d;
        int          busy_cnt;
        ef = model_frame(x, y, c, k, lat);
        x_input = x; y_input = y; predicted_class = c; K_mode = k; latency = lat;
        report = 1'b1;
        @(negedge clk);
        report = 1'b0;
        x_input = 8'($urandom); y_input = 8'($urandom);
        predicted_class = 1'($urandom); K_mode = 1'($urandom); latency = 16'($urandom);
        busy_cnt = 0;
        for (int cyc = 1; cyc <= FRAME_CYC; cyc++) begin
            obs[cyc-1] = tx;
            if (busy === 1'b1) busy_cnt++;
            report = (cyc == ovr_at);
            @(negedge clk);
        end
        report = 1'b0;
        if (ovr_at > 0) exp_ovr = 1'b1;
        exp_count = exp_count + 8'd1;
        for (int j = 0; j < 7; j++) begin
            chk($sformatf("byte%0d_timing", j), 64'(obs[j*40 +: 40]), 64'(byte_window(ef[j*8 +: 8])));
            for (int b = 0; b < 8; b++) d[b] = obs[j*40 + (b+1)*CPB + 2];
            last_dec[j*8 +: 8] = d;
            chk($sformatf("byte%0d_data", j), 64'(d), 64'(ef[j*8 +: 8]));
        end
        chk("busy_cycles", 64'(busy_cnt), 64'(FRAME_CYC));
        chk("busy_after", 64'(busy), 64'(0));
        chk("tx_after", 64'(tx), 64'(1));
        chk("frame_count", 64'(frame_count), 64'(exp_count));
        chk("overrun", 64'(overrun), 64'(exp_ovr));
        $display("frame x=%02h y=%02h c=%0d k=%0d lat=%04h sent=%014h count=%0d ovr=%0d",
                 x, y, c, k, lat, last_dec, frame_count, overrun);
    endtask

    task automatic idle_check(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("idle_line", 64'(bad), 64'(0));
    endtask

    initial begin
        checks = 0; errors = 0; exp_count = '0; exp_ovr = 1'b0; last_dec = '0; obs = '0;
        reset = 1'b1; report = 1'b0;
        x_input = '0; y_input = '0; predicted_class = 1'b0; K_mode = 1'b0; latency = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(tx), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));
        chk("rst_count", 64'(frame_count), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        run_frame(8'h05, 8'hFB, 1'b1, 1'b1, 16'h0123, 0);
        chk("basic_frame", 64'(last_dec), 64'(56'hDF_23_01_03_FB_05_A5));
        idle_check(10);

        // Second report lands in the first busy=0 cycle
        run_frame(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 0);
        run_frame(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 0);
        idle_check(5);

        run_frame(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 50);
        idle_check(20);

        // Reset 100 cycles into a frame
        x_input = 8'h3C; y_input = 8'hC3; report = 1'b1;
        @(negedge clk);
        report = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", 64'(tx), 64'(1));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_count", 64'(frame_count), 64'(0));
        chk("midrst_overrun", 64'(overrun), 64'(0));
        reset = 1'b0;
        exp_count = '0; exp_ovr = 1'b0;
        @(negedge clk);
        run_frame(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 0);
        for (int i = 0; i < 3; i++) begin
            run_frame(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 0);
            idle_check(3);
        end

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count = '0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            run_frame(8'h00, 8'h00, 1'b0, 1'b0, 16'h0000, 0);
        end
        chk("wrap_zero", 64'(frame_count), 64'(0));
        idle_check(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
